// File: rtl/word_derotator_pipe.sv
// word_derotator_pipe
// Undoes the ingress word rotation on the egress side of the crossbar.
// Output word k is input word (k - shift) mod N. The rotation is split into
// one register stage per shift bit: stage i rotates toward higher word
// indices by 2^i words when bit i of the beat's tag is set. Every stage has
// a valid bit and its own advance condition, so bubbles are squeezed out
// even while the output is stalled.

module word_derotator_pipe #(
    parameter int N       = 8,
    parameter int W       = 8,
    parameter int SHIFT_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*W-1:0]       in_bus,
    input  logic [SHIFT_W-1:0]   in_shift,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*W-1:0]       out_bus,
    output logic [SHIFT_W-1:0]   out_shift,
    output logic                 busy
);

    localparam int BW = N * W;

    logic [SHIFT_W-1:0] validQ;
    logic [BW-1:0]      busQ [SHIFT_W];
    logic [SHIFT_W-1:0] tagQ [SHIFT_W];

    logic [SHIFT_W-1:0] advance;
    logic [SHIFT_W-1:0] validD;
    logic [BW-1:0]      busD [SHIFT_W];
    logic [SHIFT_W-1:0] tagD [SHIFT_W];

    // Moves every word amt positions toward higher indices, wrapping the top
    // words around to the bottom. N is a power of two, so the mask is the
    // modulo.
    function automatic logic [BW-1:0] rotateUp(input logic [BW-1:0] bus, input int amt);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            r[k*W +: W] = bus[((k - amt) & (N - 1)) * W +: W];
        end
        return r;
    endfunction

    // A stage may advance if it is empty or any stage after it is empty, or
    // the output is being taken; written flat so no stage waits on another's result.
    always_comb begin
        advance = '0;
        for (int i = 0; i < SHIFT_W; i++) begin
            advance[i] = out_ready;
            for (int j = i; j < SHIFT_W; j++) begin
                if (!validQ[j]) begin
                    advance[i] = 1'b1;
                end
            end
        end
    end

    // What each stage would load: the previous stage (or the input port),
    // rotated by this stage's power-of-two amount when its tag bit is set.
    always_comb begin
        validD[0] = in_valid;
        tagD[0]   = in_shift;
        busD[0]   = in_shift[0] ? rotateUp(in_bus, 1) : in_bus;
        for (int i = 1; i < SHIFT_W; i++) begin
            validD[i] = validQ[i-1];
            tagD[i]   = tagQ[i-1];
            busD[i]   = tagQ[i-1][i] ? rotateUp(busQ[i-1], 1 << i) : busQ[i-1];
        end
    end

    // Pipeline registers; payload only loads with a valid beat so the last
    // stage keeps showing the previous beat once it has drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ <= '0;
            for (int i = 0; i < SHIFT_W; i++) begin
                busQ[i] <= '0;
                tagQ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SHIFT_W; i++) begin
                if (advance[i]) begin
                    validQ[i] <= validD[i];
                    if (validD[i]) begin
                        busQ[i] <= busD[i];
                        tagQ[i] <= tagD[i];
                    end
                end
            end
        end
    end

    assign in_ready  = advance[0];
    assign out_valid = validQ[SHIFT_W-1];
    assign out_bus   = busQ[SHIFT_W-1];
    assign out_shift = tagQ[SHIFT_W-1];
    assign busy      = |validQ;

endmodule

// File: tb/tb_word_derotator_pipe.sv
// Testbench for word_derotator_pipe (N=8, W=8).
// A negedge scoreboard models the block as a FIFO of de-rotated beats and
// checks every output transfer, in_ready, busy and stall stability; directed
// sequences cover latency, round trip, backpressure and mid-stream reset.

module tb_word_derotator_pipe;

    localparam int N   = 8;
    localparam int W   = 8;
    localparam int SW  = $clog2(N);
    localparam int BW  = N * W;
    localparam int LAT = SW - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_bus = '0;
    logic [SW-1:0] in_shift = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_bus;
    logic [SW-1:0] out_shift;
    logic          busy;

    int errors = 0;
    int checks = 0;

    word_derotator_pipe #(.N(N), .W(W), .SHIFT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus), .in_shift(in_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus), .out_shift(out_shift),
        .busy(busy)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: de-rotation is a left rotate of the flat bus by s words
    function automatic logic [BW-1:0] derotate(input logic [BW-1:0] bus, input int s);
        logic [2*BW-1:0] d;
        d = {bus, bus} << (s * W);
        return d[2*BW-1:BW];
    endfunction

    // Forward rotation used on ingress: out[k] = in[(k+s) % N]
    function automatic logic [BW-1:0] forwardRotate(input logic [BW-1:0] bus, input int s);
        logic [2*BW-1:0] d;
        d = {bus, bus} >> (s * W);
        return d[BW-1:0];
    endfunction

    logic [BW-1:0] expQ[$];
    logic [SW-1:0] expShQ[$];
    int            occ = 0;
    int            acceptedCount = 0;
    bit            lastInFire = 1'b0;
    bit            prevStall = 1'b0;
    logic [BW-1:0] prevBus;
    logic [SW-1:0] prevSh;

    // Scoreboard: sample both handshakes mid-cycle, compare outputs with the queue model
    always @(negedge clk) begin
        bit outFire;
        if (!rst_n) begin
            check("reset_out_valid", out_valid, 0);
            check("reset_busy", busy, 0);
            check("reset_in_ready", in_ready, 1);
            check("reset_out_bus", out_bus, 0);
            expQ.delete();
            expShQ.delete();
            occ = 0;
            prevStall = 1'b0;
            lastInFire = 1'b0;
        end else begin
            if (prevStall) begin
                check("stall_valid", out_valid, 1);
                check("stall_bus", out_bus, prevBus);
                check("stall_shift", out_shift, prevSh);
            end
            check("in_ready_model", in_ready, (out_ready || occ < SW));
            check("busy_model", busy, occ > 0);
            if (occ == 0) check("idle_out_valid", out_valid, 0);
            lastInFire = in_valid && in_ready;
            outFire = out_valid && out_ready;
            if (outFire) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got 0x%0h expected no beat", out_bus);
                end else begin
                    check("sb_bus", out_bus, expQ.pop_front());
                    check("sb_shift", out_shift, expShQ.pop_front());
                end
            end
            if (lastInFire) begin
                expQ.push_back(derotate(in_bus, int'(in_shift)));
                expShQ.push_back(in_shift);
                acceptedCount++;
            end
            occ = occ + int'(lastInFire) - int'(outFire);
            prevStall = out_valid && !out_ready;
            prevBus = out_bus;
            prevSh = out_shift;
        end
    end

    typedef struct {
        logic [BW-1:0] bus;
        logic [SW-1:0] shift;
        logic [BW-1:0] expBus;
    } vec_t;

    vec_t vecs[6];

    // Offer one beat into an empty pipeline and let it be accepted
    task automatic applyStimulus(input logic [BW-1:0] bus, input logic [SW-1:0] shift);
        in_bus = bus;
        in_shift = shift;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the beat, check latency and contents, then the hold after drain
    task automatic checkOutput(input logic [BW-1:0] expBus, input logic [SW-1:0] expShift);
        int lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, LAT);
        check("vec_valid", out_valid, 1);
        check("vec_bus", out_bus, expBus);
        check("vec_shift", out_shift, expShift);
        @(posedge clk);
        #1;
        check("drained_valid", out_valid, 0);
        check("hold_bus", out_bus, expBus);
    endtask

    logic [BW-1:0] orig[N];
    logic [BW-1:0] bp[6];
    logic [SW-1:0] bpSh[6];

    initial begin
        begin : watchdog
            fork
                begin
                    #3000000;
                    $display("[TB] FAIL watchdog: got timeout expected completion");
                    errors++;
                    $display("Result: errors=%0d of %0d checks", errors, checks);
                    $fatal(1, "[TB] watchdog");
                end
            join_none
        end

        vecs[0] = '{64'h0706050403020100, 3'd1, 64'h0605040302010007};
        vecs[1] = '{64'h0706050403020100, 3'd0, 64'h0706050403020100};
        vecs[2] = '{64'h0706050403020100, 3'd7, 64'h0007060504030201};
        vecs[3] = '{64'h0706050403020100, 3'd4, 64'h0302010007060504};
        vecs[4] = '{64'h1122334455667788, 3'd3, 64'h4455667788112233};
        vecs[5] = '{64'hDEADBEEFCAFEF00D, 3'd2, 64'hBEEFCAFEF00DDEAD};

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single beats
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].bus, vecs[v].shift);
            checkOutput(vecs[v].expBus, vecs[v].shift);
        end

        // Round trip: forward-rotated beats back to back recover the originals
        begin
            int got = 0;
            int firstCyc = -1;
            int lastCyc = -1;
            for (int s = 0; s < N; s++) orig[s] = {$urandom, $urandom};
            out_ready = 1'b1;
            for (int cyc = 0; cyc < N + LAT + 4; cyc++) begin
                if (cyc < N) begin
                    in_valid = 1'b1;
                    in_bus = forwardRotate(orig[cyc], cyc);
                    in_shift = SW'(cyc);
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (out_valid) begin
                    if (got < N) check("roundtrip_bus", out_bus, orig[got]);
                    if (firstCyc < 0) firstCyc = cyc;
                    lastCyc = cyc;
                    got++;
                end
                @(posedge clk);
                #1;
            end
            check("roundtrip_count", got, N);
            check("roundtrip_fill", firstCyc, LAT + 1);
            check("roundtrip_back_to_back", lastCyc - firstCyc, N - 1);
        end

        // Backpressure: 6 beats, output stalled for 5 cycles
        begin
            int idx = 0;
            int got = 0;
            bit fire;
            logic [BW-1:0] held;
            held = '0;
            for (int b = 0; b < 6; b++) begin
                bp[b] = {$urandom, $urandom};
                bpSh[b] = SW'($urandom_range(0, N - 1));
            end
            for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
                out_ready = (cyc >= 5);
                in_valid = (idx < 6);
                if (idx < 6) begin
                    in_bus = bp[idx];
                    in_shift = bpSh[idx];
                end
                #1;
                fire = in_valid && in_ready;
                if (cyc == 2) check("bp_ready_filling", in_ready, 1);
                if (cyc == 3 || cyc == 4) check("bp_ready_full", in_ready, 0);
                if (cyc == 3) held = out_bus;
                if (cyc == 4) check("bp_bus_stable", out_bus, held);
                if (out_valid && out_ready) begin
                    check("bp_bus", out_bus, derotate(bp[got], int'(bpSh[got])));
                    got++;
                end
                @(posedge clk);
                #1;
                if (fire) idx++;
            end
            in_valid = 1'b0;
            check("bp_accepted", idx, 6);
            check("bp_received", got, 6);
        end

        // Reset with two beats in flight
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_bus = 64'h0123456789ABCDEF;
        in_shift = 3'd5;
        @(posedge clk);
        #1;
        in_bus = 64'hFEDCBA9876543210;
        in_shift = 3'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_bus", out_bus, 0);
        check("midreset_busy", busy, 0);
        check("midreset_in_ready", in_ready, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check("midreset_no_output", out_valid, 0);
        end
        applyStimulus(vecs[0].bus, vecs[0].shift);
        checkOutput(vecs[0].expBus, vecs[0].shift);

        // Random valid/ready on both ports, 10k beats against the queue model
        begin
            int startCount = acceptedCount;
            int cyc = 0;
            in_valid = 1'b0;
            while (acceptedCount < startCount + 10000 && cyc < 60000) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (!(in_valid && !lastInFire)) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_bus = {$urandom, $urandom};
                    in_shift = SW'($urandom_range(0, N - 1));
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            check("random_no_timeout", cyc < 60000, 1);
            in_valid = 1'b0;
            out_ready = 1'b1;
            cyc = 0;
            while ((expQ.size() != 0 || busy) && cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check("random_drained", expQ.size(), 0);
            check("random_idle", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
